// File: rtl/bus_deserializer_pkg.sv
// Shared definitions for the 8-bit AES/SHA command bus (arbiter and deserializer).
package bus_deserializer_pkg;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_AES  = 2'b01;
  localparam logic [1:0] SRC_SHA  = 2'b10;

  localparam int ADDR_LSB = 0;

  // Bytes per command word {opcode, addr}
  function automatic int bus_bytes(input int addrw);
    return (addrw + 8) / 8;
  endfunction

  function automatic int opc_lsb(input int addrw);
    return addrw;
  endfunction

  function automatic logic src_legal(input logic [1:0] src);
    return (src == SRC_AES) || (src == SRC_SHA);
  endfunction

endpackage

// File: rtl/bus_deserializer_if.sv
// Byte-side and word-side handshake signals of the command bus receiver.
interface bus_deserializer_if #(
  parameter int ADDRW = 24
);
  logic [7:0]       data_in;
  logic             valid_in;
  logic [1:0]       src_in;
  logic             ready_out;
  logic [ADDRW-1:0] out_addr;
  logic [7:0]       out_opcode;
  logic [1:0]       out_src;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  data_in, valid_in, src_in, out_ready,
    output ready_out, out_addr, out_opcode, out_src, out_valid
  );

  modport master (
    output data_in, valid_in, src_in, out_ready,
    input  ready_out, out_addr, out_opcode, out_src, out_valid
  );
endinterface

// File: rtl/bus_rx_outreg.sv
// Single-entry valid/ready holding register for reassembled command words.
module bus_rx_outreg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] word_i,
  input  logic [1:0]   src_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] word_o,
  output logic [1:0]   src_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] word_q;
  logic [1:0]   src_q;

  // A load in the same cycle as a drain keeps the slot full with the new word
  always_comb begin
    valid_d = valid_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (load_i)             valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      src_q   <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        word_q <= word_i;
        src_q  <= src_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign word_o  = word_q;
  assign src_o   = src_q;

endmodule

// File: rtl/bus_deserializer.sv
// Reassembles LSB-first command bytes into {opcode, addr} words and flags framing faults.
module bus_deserializer
  import bus_deserializer_pkg::*;
#(
  parameter int ADDRW   = 24,
  parameter int TIMEOUT = 16,
  parameter int ERRW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  bus_deserializer_if.slave bus,
  output logic             frame_err,
  output logic [ERRW-1:0]  err_count
);

  localparam int NBYTES  = bus_bytes(ADDRW);
  localparam int WORDW   = ADDRW + 8;
  localparam int OPC_OFF = opc_lsb(ADDRW);
  localparam int IDXW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NBYTES - 1);
  localparam logic [TW-1:0]   TIMER_LIM = TW'(TIMEOUT);

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_COLLECT = 1'b1;

  logic            state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [1:0]      cur_src_q, cur_src_d;
  logic [TW-1:0]   timer_q, timer_d, timer_inc;
  logic            frame_err_q, frame_err_d;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;

  logic             ready;
  logic             accept;
  logic             lane_we;
  logic             load;
  logic [ADDRW-1:0] asm_w;
  logic             slot_valid;
  logic [WORDW-1:0] slot_word;
  logic [1:0]       slot_src;

  // Only the final byte needs the output slot, so only it can stall
  assign ready     = (idx_q != IDX_LAST) || !slot_valid || bus.out_ready;
  assign accept    = bus.valid_in && ready;
  assign timer_inc = timer_q + TW'(1);

  for (genvar gi = 0; gi < NBYTES - 1; gi++) begin : g_lane
    logic [7:0] lane_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        lane_q <= '0;
      end else if (lane_we && (idx_q == IDXW'(gi))) begin
        lane_q <= bus.data_in;
      end
    end

    assign asm_w[8*gi +: 8] = lane_q;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cur_src_d   = cur_src_q;
    timer_d     = '0;
    frame_err_d = 1'b0;
    lane_we     = 1'b0;
    load        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!src_legal(bus.src_in)) begin
            frame_err_d = 1'b1;
          end else begin
            state_d   = ST_COLLECT;
            idx_d     = IDXW'(1);
            cur_src_d = bus.src_in;
            lane_we   = 1'b1;
          end
        end
      end
      default: begin
        if (accept) begin
          // cur_src is always legal, so a mismatch also covers illegal codes
          if (bus.src_in != cur_src_q) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
            idx_d       = '0;
          end else if (idx_q == IDX_LAST) begin
            load    = 1'b1;
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            lane_we = 1'b1;
            idx_d   = idx_q + IDXW'(1);
          end
        end else if (TIMEOUT != 0) begin
          if (timer_inc == TIMER_LIM) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
            idx_d       = '0;
          end else begin
            timer_d = timer_inc;
          end
        end
      end
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERRW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cur_src_q   <= SRC_NONE;
      timer_q     <= '0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cur_src_q   <= cur_src_d;
      timer_q     <= timer_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  bus_rx_outreg #(
    .W(WORDW)
  ) u_outreg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .word_i  ({bus.data_in, asm_w}),
    .src_i   (cur_src_q),
    .ready_i (bus.out_ready),
    .valid_o (slot_valid),
    .word_o  (slot_word),
    .src_o   (slot_src)
  );

  assign bus.ready_out  = ready;
  assign bus.out_valid  = slot_valid;
  assign bus.out_addr   = slot_word[ADDR_LSB +: ADDRW];
  assign bus.out_opcode = slot_word[OPC_OFF +: 8];
  assign bus.out_src    = slot_src;
  assign frame_err      = frame_err_q;
  assign err_count      = err_cnt_q;

endmodule
